// File: rtl/histeq_lut_sequencer.sv
// rtl/histeq_lut_sequencer.sv - sequences one histogram-equalisation pass:
// arms the histogram calculator, reads 256 bins, accumulates the CDF and writes the 8-bit LUT.
module histeq_lut_sequencer #(
  parameter int PIXELS_LOG2 = 10,
  parameter int ARM_CYCLES  = 4,
  parameter int TIMEOUT     = 2**24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        calc_flag,
  input  logic        hist_valid,
  output logic [7:0]  hist_addr,
  input  logic [15:0] hist_data,
  output logic        lut_we,
  output logic [7:0]  lut_addr,
  output logic [7:0]  lut_data,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state;
  logic [ARM_W-1:0] arm_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             drain_cnt;

  logic             rd_valid;
  logic [7:0]       rd_addr;
  logic [23:0]      cdf;
  logic [24:0]      cdf_sum;
  logic [23:0]      cdf_next;
  logic [31:0]      product;
  logic [31:0]      scaled;
  logic [7:0]       lut_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      arm_cnt   <= '0;
      to_cnt    <= '0;
      drain_cnt <= 1'b0;
      hist_addr <= '0;
      calc_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ARM;
            busy      <= 1'b1;
            calc_flag <= 1'b1;
            arm_cnt   <= '0;
          end
        end
        S_ARM: begin
          if (arm_cnt == ARM_W'(ARM_CYCLES - 1)) begin
            state     <= S_WAIT;
            calc_flag <= 1'b0;
            to_cnt    <= '0;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (hist_valid) begin
            state     <= S_READ;
            hist_addr <= '0;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (hist_addr == 8'hFF) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            hist_addr <= hist_addr + 8'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          calc_flag <= 1'b0;
        end
      endcase
    end
  end

  // Saturating CDF: a wrap would turn the top of the LUT into dark values.
  always_comb begin
    cdf_sum   = {1'b0, cdf} + {9'd0, hist_data};
    cdf_next  = cdf_sum[24] ? 24'hFF_FFFF : cdf_sum[23:0];
    product   = {8'd0, cdf_next} * 32'd255;
    scaled    = product >> PIXELS_LOG2;
    lut_value = (scaled > 32'd255) ? 8'd255 : scaled[7:0];
  end

  // hist_data lags hist_addr by one cycle, so the write stage follows a delayed address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_addr  <= '0;
      cdf      <= '0;
      lut_we   <= 1'b0;
      lut_addr <= '0;
      lut_data <= '0;
    end else begin
      rd_valid <= (state == S_READ);
      rd_addr  <= hist_addr;
      if (state == S_WAIT && hist_valid) begin
        cdf <= '0;
      end else if (rd_valid) begin
        cdf <= cdf_next;
      end
      lut_we <= rd_valid;
      if (rd_valid) begin
        lut_addr <= rd_addr;
        lut_data <= lut_value;
      end
    end
  end

endmodule
